// File: rtl/cam_lookup_insert_ctrl.sv
// rtl/cam_lookup_insert_ctrl.sv - request sequencer for a 32-row CAM: lookup and insert-if-absent
// Occupancy bitmap allocates free rows; round-robin victim pointer takes over once the CAM is full.
module cam_lookup_insert_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_insert_i,
  input  logic [DATA_W-1:0]   req_key_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_hit_o,
  output logic [IDX_W-1:0]    rsp_index_o,
  output logic                rsp_inserted_o,
  output logic                rsp_evicted_o,
  output logic                cam_search_enable_o,
  output logic [DATA_W-1:0]   cam_search_data_o,
  input  logic                cam_search_valid_i,
  input  logic [IDX_W-1:0]    cam_search_index_i,
  output logic                cam_write_enable_o,
  output logic [IDX_W-1:0]    cam_write_index_o,
  output logic [DATA_W-1:0]   cam_write_data_o,
  output logic [IDX_W:0]      occupancy_o
);

  typedef enum logic [2:0] {IDLE, SEARCH, EVAL, WRITE, RESP} state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    key_q;
  logic                 insert_q;
  logic [IDX_W-1:0]     target_q;
  logic [ENTRIES-1:0]   bitmap_q;
  logic [IDX_W:0]       occ_q;
  logic [IDX_W-1:0]     victim_q;
  logic                 rsp_hit_q, rsp_inserted_q, rsp_evicted_q;
  logic [IDX_W-1:0]     rsp_index_q;
  logic [IDX_W-1:0]     free_idx;
  logic                 full;

  assign full = (occ_q == (IDX_W+1)'(ENTRIES));

  // Descending scan so the lowest clear bit is the last assignment to win.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    req_ready_o         = 1'b0;
    rsp_valid_o         = 1'b0;
    cam_search_enable_o = 1'b0;
    cam_search_data_o   = '0;
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = SEARCH;
      end
      SEARCH: begin
        cam_search_enable_o = 1'b1;
        cam_search_data_o   = key_q;
        state_d             = EVAL;
      end
      EVAL: begin
        if (!cam_search_valid_i && insert_q) state_d = WRITE;
        else                                 state_d = RESP;
      end
      WRITE: begin
        cam_write_enable_o = 1'b1;
        cam_write_index_o  = target_q;
        cam_write_data_o   = key_q;
        state_d            = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      key_q          <= '0;
      insert_q       <= 1'b0;
      target_q       <= '0;
      bitmap_q       <= '0;
      occ_q          <= '0;
      victim_q       <= '0;
      rsp_hit_q      <= 1'b0;
      rsp_index_q    <= '0;
      rsp_inserted_q <= 1'b0;
      rsp_evicted_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            key_q          <= req_key_i;
            insert_q       <= req_insert_i;
            rsp_hit_q      <= 1'b0;
            rsp_index_q    <= '0;
            rsp_inserted_q <= 1'b0;
            rsp_evicted_q  <= 1'b0;
          end
        end
        EVAL: begin
          if (cam_search_valid_i) begin
            rsp_hit_q   <= 1'b1;
            rsp_index_q <= cam_search_index_i;
          end else if (insert_q) begin
            target_q      <= full ? victim_q : free_idx;
            rsp_evicted_q <= full;
          end
        end
        WRITE: begin
          bitmap_q[target_q] <= 1'b1;
          if (!bitmap_q[target_q] && !full) occ_q <= occ_q + 1'b1;
          // Power-of-two row count makes the natural wrap the round-robin wrap.
          if (rsp_evicted_q) victim_q <= victim_q + 1'b1;
          rsp_inserted_q <= 1'b1;
          rsp_index_q    <= target_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_hit_o      = rsp_hit_q;
  assign rsp_index_o    = rsp_index_q;
  assign rsp_inserted_o = rsp_inserted_q;
  assign rsp_evicted_o  = rsp_evicted_q;
  assign occupancy_o    = occ_q;

endmodule

// File: tb/tb_cam_lookup_insert_ctrl.sv
// tb/tb_cam_lookup_insert_ctrl.sv - directed vector bench for cam_lookup_insert_ctrl with a behavioural CAM
module tb_cam_lookup_insert_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_insert_i;
  logic [31:0] req_key_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_hit_o, rsp_inserted_o, rsp_evicted_o;
  logic [4:0]  rsp_index_o;
  logic        cam_search_enable_o, cam_search_valid_i, cam_write_enable_o;
  logic [31:0] cam_search_data_o, cam_write_data_o;
  logic [4:0]  cam_search_index_i, cam_write_index_o;
  logic [5:0]  occupancy_o;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  cam_lookup_insert_ctrl dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_insert_i(req_insert_i), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_index_o(rsp_index_o),
    .rsp_inserted_o(rsp_inserted_o), .rsp_evicted_o(rsp_evicted_o),
    .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i),
    .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o), .occupancy_o(occupancy_o)
  );

  // Behavioural CAM: registered search result, lowest matching row wins.
  logic [31:0] cam_mem [32];
  logic [31:0] cam_vld;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cam_vld            <= '0;
      cam_search_valid_i <= 1'b0;
      cam_search_index_i <= '0;
    end else begin
      if (cam_search_enable_o) begin
        logic       m;
        logic [4:0] mi;
        m = 1'b0;
        mi = '0;
        for (int i = 31; i >= 0; i--) begin
          if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
            m = 1'b1;
            mi = 5'(i);
          end
        end
        cam_search_valid_i <= m;
        cam_search_index_i <= mi;
      end
      if (cam_write_enable_o) begin
        cam_mem[cam_write_index_o] <= cam_write_data_o;
        cam_vld[cam_write_index_o] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit          ins;
    logic [31:0] key;
    bit          hit;
    int          idx;
    bit          inserted;
    bit          evicted;
    int          lat;
    int          occ;
  } vec_t;

  function automatic vec_t mk(bit ins, logic [31:0] key, bit hit, int idx,
                              bit inserted, bit evicted, int lat, int occ);
    vec_t v;
    v.ins = ins; v.key = key; v.hit = hit; v.idx = idx;
    v.inserted = inserted; v.evicted = evicted; v.lat = lat; v.occ = occ;
    return v;
  endfunction

  // Issues one request from IDLE with rsp_ready_i high; returns at the negedge after acceptance.
  task automatic run_req(input bit ins, input logic [31:0] key,
                         output logic hit, output logic [4:0] idx, output logic inserted,
                         output logic ev, output int lat, output bit wpulse, output bit clash);
    int k;
    wpulse = 1'b0;
    clash = 1'b0;
    k = 0;
    while (!req_ready_o && k < 20) begin @(negedge clk); k++; end
    req_valid_i = 1'b1; req_insert_i = ins; req_key_i = key;
    @(negedge clk);
    req_valid_i = 1'b0;
    k = 0;
    while (!rsp_valid_o && k < 20) begin
      @(negedge clk);
      k++;
      if (cam_write_enable_o) wpulse = 1'b1;
      if (cam_write_enable_o && cam_search_enable_o) clash = 1'b1;
    end
    hit = rsp_hit_o; idx = rsp_index_o; inserted = rsp_inserted_o; ev = rsp_evicted_o;
    lat = rsp_valid_o ? k + 1 : -1;
    @(negedge clk);
  endtask

  vec_t        tbl[$];
  logic        hit, inserted, ev;
  logic [4:0]  idx;
  int          lat;
  bit          wpulse, clash;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_insert_i = 1'b0; req_key_i = '0; rsp_ready_i = 1'b1;

    tbl.push_back(mk(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 32'h1111_0000, 0, 0, 1, 0, 4, 1));
    tbl.push_back(mk(1, 32'h2222_0000, 0, 1, 1, 0, 4, 2));
    tbl.push_back(mk(0, 32'h2222_0000, 1, 1, 0, 0, 3, 2));
    tbl.push_back(mk(1, 32'h1111_0000, 1, 0, 0, 0, 3, 2));
    for (int i = 2; i < 32; i++) tbl.push_back(mk(1, 32'h3000_0000 + i, 0, i, 1, 0, 4, i + 1));
    tbl.push_back(mk(1, 32'hAAAA_0001, 0, 0, 1, 1, 4, 32));
    tbl.push_back(mk(1, 32'hAAAA_0002, 0, 1, 1, 1, 4, 32));
    tbl.push_back(mk(0, 32'h1111_0000, 0, 0, 0, 0, 3, 32));
    tbl.push_back(mk(0, 32'h2222_0000, 0, 0, 0, 0, 3, 32));
    tbl.push_back(mk(1, 32'hAAAA_0001, 1, 0, 0, 0, 3, 32));
    tbl.push_back(mk(1, 32'hAAAA_0003, 0, 2, 1, 1, 4, 32));
    tbl.push_back(mk(0, 32'h3000_0002, 0, 0, 0, 0, 3, 32));
    tbl.push_back(mk(0, 32'h3000_0004, 1, 4, 0, 0, 3, 32));

    repeat (2) @(negedge clk);
    chk("reset req_ready", req_ready_o, 1);
    chk("reset rsp_valid", rsp_valid_o, 0);
    chk("reset outputs", {rsp_hit_o, rsp_index_o, rsp_inserted_o, rsp_evicted_o,
                          cam_search_enable_o, cam_write_enable_o, cam_write_index_o}, 0);
    chk("reset occupancy", occupancy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    foreach (tbl[n]) begin
      run_req(tbl[n].ins, tbl[n].key, hit, idx, inserted, ev, lat, wpulse, clash);
      chk($sformatf("v%0d hit", n), hit, tbl[n].hit);
      chk($sformatf("v%0d index", n), idx, tbl[n].idx);
      chk($sformatf("v%0d inserted", n), inserted, tbl[n].inserted);
      chk($sformatf("v%0d evicted", n), ev, tbl[n].evicted);
      chk($sformatf("v%0d latency", n), lat, tbl[n].lat);
      chk($sformatf("v%0d write pulse", n), wpulse, tbl[n].inserted);
      chk($sformatf("v%0d enable overlap", n), clash, 0);
      chk($sformatf("v%0d occupancy", n), occupancy_o, tbl[n].occ);
    end

    // Backpressure: response held for 5 cycles while a new request is presented.
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_insert_i = 1'b0; req_key_i = 32'h3000_0003;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid_o; k++) @(negedge clk);
    chk("hold rsp_valid", rsp_valid_o, 1);
    req_valid_i = 1'b1; req_insert_i = 1'b1; req_key_i = 32'h5555_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d fields", c),
          {rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_inserted_o, rsp_evicted_o}, {1'b1, 1'b1, 5'd3, 1'b0, 1'b0});
      chk($sformatf("hold%0d req_ready", c), req_ready_o, 0);
      chk($sformatf("hold%0d no search", c), cam_search_enable_o, 0);
    end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("release rsp_valid", rsp_valid_o, 0);
    chk("release req_ready", req_ready_o, 1);
    run_req(0, 32'h5555_0000, hit, idx, inserted, ev, lat, wpulse, clash);
    chk("ignored insert absent", hit, 0);
    chk("ignored insert occupancy", occupancy_o, 32);

    // Reset during WRITE abandons the insert.
    req_valid_i = 1'b1; req_insert_i = 1'b1; req_key_i = 32'h7777_0000;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 0; k < 10 && !cam_write_enable_o; k++) @(negedge clk);
    chk("reached write", cam_write_enable_o, 1);
    rst_i = 1'b1;
    #1;
    chk("reset kills write", cam_write_enable_o, 0);
    chk("reset occupancy mid-op", occupancy_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset no rsp%0d", c), rsp_valid_o, 0);
    end
    run_req(0, 32'h7777_0000, hit, idx, inserted, ev, lat, wpulse, clash);
    chk("aborted key misses", hit, 0);
    chk("aborted key latency", lat, 3);
    run_req(1, 32'h7777_0000, hit, idx, inserted, ev, lat, wpulse, clash);
    chk("reinsert index", idx, 0);
    chk("reinsert not evicted", {inserted, ev}, 2'b10);
    chk("reinsert occupancy", occupancy_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
